// File: rtl/legv8_mem_sequencer.sv
// Multi-cycle control sequencer for the LEGv8 datapath with data memory.
// Accepts one decoded operation (LOAD, STORE, ALU, NOP) over valid/ready and
// drives register-file, ALU, tristate and RAM control lines until it retires.
//
//  state  | meaning
//  -------+-------------------------------------------------------------
//  IDLE   | waiting for a request; also emits the one-cycle NOP done
//  ADDR   | address register captures Rn + Rm
//  MEM    | RAM strobes held for MEM_WAIT cycles (read or write)
//  WB     | LOAD only: RAM data written into Rd
//  EXEC   | register ALU op, result written into Rd
module legv8_mem_sequencer #(
   parameter int         MEM_WAIT = 1,
   parameter logic [4:0] FS_ADD   = 5'b01000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [1:0] req_op,
   input  logic [4:0] req_rd,
   input  logic [4:0] req_rn,
   input  logic [4:0] req_rm,
   input  logic [4:0] req_fs,
   input  logic       req_c0,
   input  logic [1:0] req_size,
   output logic       busy,
   output logic       done,
   output logic [4:0] DA,
   output logic [4:0] SA,
   output logic [4:0] SB,
   output logic       W,
   output logic [4:0] FS,
   output logic       C0,
   output logic       EN_ALU,
   output logic       EN_B,
   output logic       EN_ADDR_ALU,
   output logic       chip_select,
   output logic       write_enable,
   output logic       output_enable,
   output logic [1:0] size
);

   localparam logic [1:0] OP_LOAD  = 2'b00;
   localparam logic [1:0] OP_STORE = 2'b01;
   localparam logic [1:0] OP_ALU   = 2'b10;
   localparam logic [1:0] OP_NOP   = 2'b11;

   // A zero wait is promoted to one cycle; the counter is 4 bits wide.
   localparam int         WAIT_EFF  = (MEM_WAIT < 1) ? 1 : ((MEM_WAIT > 15) ? 15 : MEM_WAIT);
   localparam logic [3:0] WAIT_LOAD = 4'(WAIT_EFF - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_MEM,
      S_WB,
      S_EXEC
   } state_t;

   state_t     state;
   state_t     state_nx;
   logic [3:0] wait_cnt;
   logic       nop_done;
   logic [1:0] op_q;
   logic [4:0] rd_q;
   logic [4:0] rn_q;
   logic [4:0] rm_q;
   logic [4:0] fs_q;
   logic       c0_q;
   logic [1:0] size_q;
   logic       accept;

   assign accept = req_valid && req_ready;

   // State register, NOP completion flag and MEM wait down-counter.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state    <= S_IDLE;
         nop_done <= 1'b0;
         wait_cnt <= '0;
      end else begin
         state    <= state_nx;
         nop_done <= accept && (req_op == OP_NOP);
         if (state == S_ADDR)
            wait_cnt <= WAIT_LOAD;
         else if (state == S_MEM && wait_cnt != 4'd0)
            wait_cnt <= wait_cnt - 4'd1;
      end
   end

   // Request fields are captured only on the accept edge.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         op_q   <= OP_NOP;
         rd_q   <= '0;
         rn_q   <= '0;
         rm_q   <= '0;
         fs_q   <= '0;
         c0_q   <= 1'b0;
         size_q <= '0;
      end else if (accept) begin
         op_q   <= req_op;
         rd_q   <= req_rd;
         rn_q   <= req_rn;
         rm_q   <= req_rm;
         fs_q   <= req_fs;
         c0_q   <= req_c0;
         size_q <= req_size;
      end
   end

   // Next state and Moore-decoded control outputs.
   always_comb begin
      state_nx      = state;
      busy          = (state != S_IDLE);
      req_ready     = 1'b0;
      done          = 1'b0;
      DA            = '0;
      SA            = '0;
      SB            = '0;
      W             = 1'b0;
      FS            = '0;
      C0            = 1'b0;
      EN_ALU        = 1'b0;
      EN_B          = 1'b0;
      EN_ADDR_ALU   = 1'b0;
      chip_select   = 1'b0;
      write_enable  = 1'b0;
      output_enable = 1'b0;
      size          = '0;
      case (state)
         S_IDLE: begin
            // The NOP done cycle blocks acceptance so done never overlaps an accept.
            done      = nop_done;
            req_ready = !nop_done;
            if (req_valid && !nop_done) begin
               case (req_op)
                  OP_LOAD, OP_STORE: state_nx = S_ADDR;
                  OP_ALU:            state_nx = S_EXEC;
                  default:           state_nx = S_IDLE;
               endcase
            end
         end
         S_ADDR: begin
            SA          = rn_q;
            SB          = rm_q;
            FS          = FS_ADD;
            EN_ADDR_ALU = 1'b1;
            state_nx    = S_MEM;
         end
         S_MEM: begin
            chip_select = 1'b1;
            size        = size_q;
            if (op_q == OP_STORE) begin
               SB           = rm_q;
               EN_B         = 1'b1;
               write_enable = 1'b1;
               if (wait_cnt == 4'd0) begin
                  done     = 1'b1;
                  state_nx = S_IDLE;
               end
            end else begin
               output_enable = 1'b1;
               if (wait_cnt == 4'd0)
                  state_nx = S_WB;
            end
         end
         S_WB: begin
            chip_select   = 1'b1;
            output_enable = 1'b1;
            size          = size_q;
            DA            = rd_q;
            W             = 1'b1;
            done          = 1'b1;
            state_nx      = S_IDLE;
         end
         S_EXEC: begin
            SA       = rn_q;
            SB       = rm_q;
            FS       = fs_q;
            C0       = c0_q;
            EN_ALU   = 1'b1;
            DA       = rd_q;
            W        = 1'b1;
            done     = 1'b1;
            state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_legv8_mem_sequencer.sv
// Bench for legv8_mem_sequencer: each accepted operation expands into its
// expected per-cycle control timeline, which is compared against the DUT.
module tb_legv8_mem_sequencer;

   localparam int         WAIT   = 3;
   localparam logic [4:0] FS_ADD = 5'b01000;

   typedef struct packed {
      logic       ready;
      logic       busy;
      logic       done;
      logic [4:0] da;
      logic [4:0] sa;
      logic [4:0] sb;
      logic       w;
      logic [4:0] fs;
      logic       c0;
      logic       en_alu;
      logic       en_b;
      logic       en_addr;
      logic       cs;
      logic       we;
      logic       oe;
      logic [1:0] size;
   } outv_t;

   logic       clock = 1'b0;
   logic       reset;
   logic       req_valid;
   logic       req_ready;
   logic [1:0] req_op;
   logic [4:0] req_rd, req_rn, req_rm, req_fs;
   logic       req_c0;
   logic [1:0] req_size;
   logic       busy, done;
   logic [4:0] DA, SA, SB, FS;
   logic       W, C0, EN_ALU, EN_B, EN_ADDR_ALU;
   logic       chip_select, write_enable, output_enable;
   logic [1:0] size;

   int n_checks = 0;
   int n_pass   = 0;
   int n_accept = 0;
   int n_abort  = 0;
   int n_done   = 0;
   outv_t sched[$];

   legv8_mem_sequencer #(.MEM_WAIT(WAIT), .FS_ADD(FS_ADD)) dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_rd(req_rd), .req_rn(req_rn), .req_rm(req_rm), .req_fs(req_fs),
      .req_c0(req_c0), .req_size(req_size),
      .busy(busy), .done(done), .DA(DA), .SA(SA), .SB(SB), .W(W), .FS(FS),
      .C0(C0), .EN_ALU(EN_ALU), .EN_B(EN_B), .EN_ADDR_ALU(EN_ADDR_ALU),
      .chip_select(chip_select), .write_enable(write_enable),
      .output_enable(output_enable), .size(size)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%h exp=%h", tag, got, exp);
   endtask

   function automatic outv_t observe();
      outv_t o;
      o = '{req_ready, busy, done, DA, SA, SB, W, FS, C0, EN_ALU, EN_B,
            EN_ADDR_ALU, chip_select, write_enable, output_enable, size};
      return o;
   endfunction

   function automatic outv_t idle_vec();
      outv_t e;
      e = '0;
      e.ready = 1'b1;
      return e;
   endfunction

   // Expected control timeline of one operation, starting the cycle after accept.
   task automatic plan(input logic [1:0] op, input logic [4:0] rd, rn, rm, fs,
                       input logic c0, input logic [1:0] sz);
      outv_t e;
      if (op == 2'b00 || op == 2'b01) begin
         e = '0; e.busy = 1; e.sa = rn; e.sb = rm; e.fs = FS_ADD; e.en_addr = 1;
         sched.push_back(e);
         for (int i = 0; i < WAIT; i++) begin
            e = '0; e.busy = 1; e.cs = 1; e.size = sz;
            if (op == 2'b00) e.oe = 1;
            else begin
               e.we = 1; e.sb = rm; e.en_b = 1; e.done = (i == WAIT - 1);
            end
            sched.push_back(e);
         end
         if (op == 2'b00) begin
            e = '0; e.busy = 1; e.cs = 1; e.oe = 1; e.size = sz;
            e.da = rd; e.w = 1; e.done = 1;
            sched.push_back(e);
         end
      end else if (op == 2'b10) begin
         e = '0; e.busy = 1; e.sa = rn; e.sb = rm; e.fs = fs; e.c0 = c0;
         e.en_alu = 1; e.da = rd; e.w = 1; e.done = 1;
         sched.push_back(e);
      end else begin
         e = '0; e.done = 1;
         sched.push_back(e);
      end
   endtask

   // One cycle: check outputs at the falling edge, then drive the next request.
   task automatic step(input string tag, input logic v, input logic [1:0] op,
                       input logic [4:0] rd, rn, rm, fs, input logic c0,
                       input logic [1:0] sz);
      outv_t exp, got;
      @(negedge clock);
      exp = (sched.size() != 0) ? sched.pop_front() : idle_vec();
      got = observe();
      check(tag, 64'(got), 64'(exp));
      check("excl", {62'd0, (int'(EN_ALU) + int'(EN_B) + int'(output_enable)) <= 1,
                     !(write_enable && output_enable)}, 64'd3);
      if (done) n_done++;
      req_valid = v; req_op = op; req_rd = rd; req_rn = rn; req_rm = rm;
      req_fs = fs; req_c0 = c0; req_size = sz;
      if (exp.ready && v) begin
         plan(op, rd, rn, rm, fs, c0, sz);
         n_accept++;
      end
   endtask

   task automatic idle_step(input string tag);
      step(tag, 1'b0, 2'b00, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 2'b00);
   endtask

   task automatic async_reset(input string tag);
      outv_t exp;
      if (sched.size() != 0) n_abort++;
      sched.delete();
      reset = 1'b1;
      #1;
      exp = idle_vec();
      check(tag, 64'(observe()), 64'(exp));
   endtask

   initial begin
      reset = 1'b1; req_valid = 0; req_op = 0; req_rd = 0; req_rn = 0;
      req_rm = 0; req_fs = 0; req_c0 = 0; req_size = 0;
      idle_step("reset_hold");
      reset = 1'b0;
      idle_step("idle");

      // Reset mid-cycle while idle, then release.
      @(posedge clock); #2;
      async_reset("rst_idle");
      idle_step("rst_idle_hold");
      reset = 1'b0;
      idle_step("after_rst");

      // Directed LOAD, STORE, ALU, NOP, with busy-time garbage on the inputs.
      step("load_acc", 1, 2'b00, 5'd5, 5'd1, 5'd2, 5'd0, 0, 2'b11);
      for (int i = 0; i < WAIT + 2; i++)
         step("load", 1, 2'b10, 5'd9, 5'd9, 5'd9, 5'd31, 1, 2'b01);
      step("store_acc", 1, 2'b01, 5'd0, 5'd4, 5'd7, 5'd0, 0, 2'b01);
      for (int i = 0; i < WAIT + 1; i++) idle_step("store");
      step("alu_acc", 1, 2'b10, 5'd3, 5'd4, 5'd6, 5'b00101, 1, 2'b00);
      idle_step("alu");
      step("nop_acc", 1, 2'b11, 5'd1, 5'd1, 5'd1, 5'd1, 1, 2'b11);
      step("nop", 1, 2'b10, 5'd2, 5'd2, 5'd2, 5'd2, 0, 2'b00);
      idle_step("alu2");
      idle_step("idle2");

      // Reset during the second MEM cycle of a LOAD.
      step("load2_acc", 1, 2'b00, 5'd12, 5'd13, 5'd14, 5'd0, 0, 2'b10);
      for (int i = 0; i < 3; i++) idle_step("load2");
      #2;
      async_reset("rst_mem");
      idle_step("rst_mem_hold");
      reset = 1'b0;
      for (int i = 0; i < 4; i++) idle_step("post_rst");

      // Randomized stream with valid toggling.
      for (int i = 0; i < 600; i++)
         step("rand", ($urandom_range(0, 2) != 0), 2'($urandom),
              5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
              1'($urandom), 2'($urandom));
      req_valid = 0;
      for (int i = 0; i < WAIT + 4; i++) idle_step("drain");

      check("done_count", 64'(n_done), 64'(n_accept - n_abort));
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
